// File: rtl/tick_sched_ctrl.sv
// tick_sched_ctrl: programmable period/duty tick scheduler.
// One period counter sequenced by start/stop/hold, in periodic or one-shot
// mode. Period/high-time updates made while running are held as pending and
// applied only at a period boundary (wrap or restart), so a period is never cut.
module tick_sched_ctrl #(
    parameter int                 WIDTH          = 24,
    parameter logic [WIDTH-1:0]   DEFAULT_PERIOD = 24'd12_000_000,
    parameter logic [WIDTH-1:0]   DEFAULT_HIGH   = 24'd6_000_000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    input  logic             cfg_oneshot,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    output logic             tick,
    output logic             done,
    output logic             wave_out,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    // Config handshake: a request transfers on a clk_in edge where
    // cfg_valid & cfg_ready are both 1. cfg_ready depends only on internal
    // state (low while a pending config waits for a boundary), never on
    // cfg_valid. A transferred request with cfg_period < 2 is dropped and
    // answered by a one-cycle cfg_err pulse.

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             oneshot_q, oneshot_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_period_q, pend_period_d;
    logic [WIDTH-1:0] pend_high_q, pend_high_d;
    logic             pend_oneshot_q, pend_oneshot_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             wave_q, wave_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic             cfg_acc;
    logic             cfg_ok;
    logic             at_wrap;

    // Next-state and next-output computation for the whole block.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        period_d       = period_q;
        high_d         = high_q;
        oneshot_d      = oneshot_q;
        pend_d         = pend_q;
        pend_period_d  = pend_period_q;
        pend_high_d    = pend_high_q;
        pend_oneshot_d = pend_oneshot_q;
        cfg_ready_d    = cfg_ready_q;
        tick_d         = 1'b0;
        done_d         = 1'b0;
        cfg_err_d      = 1'b0;

        cfg_acc = cfg_valid & cfg_ready_q;
        cfg_ok  = cfg_acc & (cfg_period >= TWO);
        at_wrap = (count_q == period_q - ONE);

        if (cfg_acc && !cfg_ok) begin
            cfg_err_d = 1'b1;
        end

        // Accepted config: immediate when idle, otherwise parked until a boundary.
        if (cfg_ok) begin
            if (state_q == IDLE) begin
                period_d  = cfg_period;
                high_d    = cfg_high;
                oneshot_d = cfg_oneshot;
            end else begin
                pend_d         = 1'b1;
                pend_period_d  = cfg_period;
                pend_high_d    = cfg_high;
                pend_oneshot_d = cfg_oneshot;
                cfg_ready_d    = 1'b0;
            end
        end

        if (stop) begin
            // Stop beats start and drops anything still pending.
            state_d     = IDLE;
            count_d     = '0;
            pend_d      = 1'b0;
            cfg_ready_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (start || (!hold && at_wrap)) begin
                        count_d = '0;
                        if (!start) begin
                            tick_d = 1'b1;
                            if (oneshot_q) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                        if (pend_q) begin
                            period_d    = pend_period_q;
                            high_d      = pend_high_q;
                            oneshot_d   = pend_oneshot_q;
                            pend_d      = 1'b0;
                            cfg_ready_d = 1'b1;
                        end
                    end else if (!hold) begin
                        count_d = count_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end

        wave_d = (state_d == RUN) && (count_d < high_d);
    end

    // State and registered outputs; asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            period_q       <= DEFAULT_PERIOD;
            high_q         <= DEFAULT_HIGH;
            oneshot_q      <= 1'b0;
            pend_q         <= 1'b0;
            pend_period_q  <= '0;
            pend_high_q    <= '0;
            pend_oneshot_q <= 1'b0;
            tick_q         <= 1'b0;
            done_q         <= 1'b0;
            wave_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            cfg_ready_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            period_q       <= period_d;
            high_q         <= high_d;
            oneshot_q      <= oneshot_d;
            pend_q         <= pend_d;
            pend_period_q  <= pend_period_d;
            pend_high_q    <= pend_high_d;
            pend_oneshot_q <= pend_oneshot_d;
            tick_q         <= tick_d;
            done_q         <= done_d;
            wave_q         <= wave_d;
            cfg_err_q      <= cfg_err_d;
            cfg_ready_q    <= cfg_ready_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign count     = count_q;
    assign tick      = tick_q;
    assign done      = done_q;
    assign wave_out  = wave_q;
    assign cfg_err   = cfg_err_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Bench for tick_sched_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the scheduler.
module tb_tick_sched_ctrl;

    localparam int W = 24;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_high;
    logic         cfg_oneshot;
    logic         cfg_err;
    logic         start;
    logic         stop;
    logic         hold;
    logic         tick;
    logic         done;
    logic         wave_out;
    logic         busy;
    logic [W-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    // Expected counter value per cycle, produced by the model.
    logic [W-1:0] exp_q[$];

    // Behavioural model: running flag, position inside the period, active
    // settings and at most one pending setting.
    bit m_run, m_pend, m_tick, m_done, m_err;
    int m_pos, m_per, m_high;
    bit m_one;
    int p_per, p_high;
    bit p_one;

    tick_sched_ctrl #(
        .WIDTH          (W),
        .DEFAULT_PERIOD (24'd10),
        .DEFAULT_HIGH   (24'd5)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_oneshot (cfg_oneshot),
        .cfg_err     (cfg_err),
        .start       (start),
        .stop        (stop),
        .hold        (hold),
        .tick        (tick),
        .done        (done),
        .wave_out    (wave_out),
        .busy        (busy),
        .count       (count)
    );

    // Clock: 10 time units per cycle.
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_tick = 0; m_done = 0; m_err = 0;
        m_pos = 0; m_per = 10; m_high = 5; m_one = 0;
        p_per = 0; p_high = 0; p_one = 0;
        exp_q.push_back(W'(m_pos));
    endtask

    // One clock edge of the scheduler's rules, applied to the inputs on that edge.
    task automatic model_edge();
        bit acc_ok, was_run, boundary, old_one;
        acc_ok  = cfg_valid && !m_pend && (cfg_period >= 2);
        m_err   = cfg_valid && !m_pend && (cfg_period < 2);
        was_run = m_run;
        m_tick  = 0;
        m_done  = 0;
        if (acc_ok && !was_run) begin
            m_per = int'(cfg_period); m_high = int'(cfg_high); m_one = cfg_oneshot;
        end
        if (stop) begin
            m_run = 0; m_pos = 0; m_pend = 0;
        end else if (!was_run) begin
            if (start) begin
                m_run = 1; m_pos = 0;
            end
        end else begin
            boundary = start || (!hold && (m_pos == m_per - 1));
            if (boundary) begin
                old_one = m_one;
                m_pos = 0;
                if (!start) begin
                    m_tick = 1;
                    if (old_one) begin
                        m_run = 0; m_done = 1;
                    end
                end
                if (m_pend) begin
                    m_per = p_per; m_high = p_high; m_one = p_one; m_pend = 0;
                end
            end else if (!hold) begin
                m_pos++;
            end
            if (acc_ok) begin
                m_pend = 1; p_per = int'(cfg_period); p_high = int'(cfg_high); p_one = cfg_oneshot;
            end
        end
        exp_q.push_back(W'(m_pos));
    endtask

    task automatic check_all();
        logic [W-1:0] e_cnt;
        if (exp_q.size() == 0) begin
            check_val("exp_q_empty", 1, 0);
            return;
        end
        e_cnt = exp_q.pop_front();
        check_val("count",     count,     e_cnt);
        check_val("busy",      busy,      m_run);
        check_val("tick",      tick,      m_tick);
        check_val("done",      done,      m_done);
        check_val("wave_out",  wave_out,  m_run && (m_pos < m_high));
        check_val("cfg_ready", cfg_ready, !m_pend);
        check_val("cfg_err",   cfg_err,   m_err);
    endtask

    // Driver tasks: inputs change 1 unit after the edge, outputs checked there too.
    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_cfg(input int p, input int h, input bit o);
        cfg_valid = 1; cfg_period = W'(p); cfg_high = W'(h); cfg_oneshot = o;
        step();
        cfg_valid = 0;
    endtask

    task automatic do_start();
        start = 1; step(); start = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int tick_t[$];
    int cyc;

    initial begin
        rst = 0; cfg_valid = 0; cfg_period = '0; cfg_high = '0; cfg_oneshot = 0;
        start = 0; stop = 0; hold = 0;
        repeat (3) @(posedge clk_in);
        #1;
        model_reset();
        check_all();
        #3 rst = 1;

        // Default settings: first tick 10 cycles after start, wave high 5 cycles.
        do_start();
        cyc = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            cyc++;
            if (tick) tick_t.push_back(cyc);
        end
        check_val("default_tick_count", tick_t.size(), 2);
        if (tick_t.size() >= 2) begin
            check_val("default_first_tick", tick_t[0], 10);
            check_val("default_spacing", tick_t[1] - tick_t[0], 10);
        end
        stop = 1; step(); stop = 0;

        // Period 4, high 1 configured in IDLE.
        do_cfg(4, 1, 0);
        do_start();
        run_cycles(10);

        // Reconfigure to 6 while running at count 1; second request must wait.
        while (m_pos != 1) step();
        do_cfg(6, 3, 0);
        check_val("pending_ready_low", cfg_ready, 0);
        do_cfg(8, 2, 0);
        run_cycles(16);
        stop = 1; step(); stop = 0;

        // One-shot, period 5.
        do_cfg(5, 2, 1);
        do_start();
        run_cycles(10);

        // Rejected config keeps the previous settings.
        do_cfg(1, 1, 0);
        do_cfg(0, 0, 0);
        do_start();
        run_cycles(7);

        // start and stop together while running.
        start = 1; stop = 1; step(); start = 0; stop = 0;
        check_val("start_stop_idle", busy, 0);

        // Hold for 3 cycles at count 2.
        do_cfg(6, 3, 0);
        do_start();
        while (m_pos != 2) step();
        hold = 1; run_cycles(3); hold = 0;
        run_cycles(10);

        // Restart mid-period, then reset with a pending config.
        do_start();
        run_cycles(2);
        do_cfg(9, 4, 1);
        check_val("pending_before_rst", cfg_ready, 0);
        #2 rst = 0;
        #1;
        exp_q.delete();
        model_reset();
        check_all();
        @(posedge clk_in);
        #3 rst = 1;
        do_start();
        run_cycles(22);
        stop = 1; step(); stop = 0;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cfg_valid   = ($urandom_range(0, 7) == 0);
            cfg_period  = W'($urandom_range(0, 9));
            cfg_high    = W'($urandom_range(0, 10));
            cfg_oneshot = ($urandom_range(0, 3) == 0);
            start       = ($urandom_range(0, 24) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            hold        = ($urandom_range(0, 5) == 0);
            if (!m_run && ($urandom_range(0, 3) == 0)) start = 1;
            step();
        end
        cfg_valid = 0; start = 0; stop = 0; hold = 0;
        run_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tick_sched_ctrl.md
# tick_sched_ctrl

Programmable tick/waveform scheduler that replaces the fixed divide-by-constant slow-clock generator in the test design. It owns one WIDTH-bit period counter and sequences it under host control: start, stop, hold, and one-shot or periodic mode. Period and high-time updates are double-buffered and applied only at period boundaries. Outputs are a one-cycle tick per period, a duty-programmable wave output and status flags, all synchronous to clk_in; none is used as a clock.

## Interface
- WIDTH, 24, counter/config width
- DEFAULT_PERIOD, 24'd12_000_000, active period after reset, in clk_in cycles
- DEFAULT_HIGH, 24'd6_000_000, active high-time after reset
- clk_in  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  config request
- cfg_ready  out  1  config can be accepted
- cfg_period  in  WIDTH  new period (cycles)
- cfg_high  in  WIDTH  new high-time (cycles)
- cfg_oneshot  in  1  1 = stop after one period
- cfg_err  out  1  one-cycle pulse: request rejected
- start  in  1  start/restart pulse
- stop  in  1  stop pulse
- hold  in  1  level; freezes counting while RUN
- tick  out  1  one-cycle pulse per completed period
- done  out  1  one-cycle pulse on one-shot completion
- wave_out  out  1  duty waveform
- busy  out  1  state is RUN
- count  out  WIDTH  current counter value

## Operation
- States: IDLE, RUN. All outputs registered.
- Reset: state IDLE, count 0, active period/high = DEFAULT_PERIOD/DEFAULT_HIGH, oneshot 0, no pending config. tick, done, wave_out, busy, cfg_err = 0; cfg_ready = 1.
- Config handshake: accepted on an edge where cfg_valid & cfg_ready.
  - cfg_period < 2: rejected. cfg_err = 1 for the next cycle, nothing stored, cfg_ready stays 1.
  - Accepted in IDLE: applied directly to the active registers.
  - Accepted in RUN: stored as pending, and cfg_ready = 0 until it is applied. It is applied on the wrap edge (count period-1 → 0); cfg_ready returns to 1 in the same cycle.
  - stop discards a pending config; cfg_ready = 1.
- IDLE → RUN: start. count = 0, busy = 1.
- RUN, hold = 0: count increments by 1 per edge. At count == period-1 the next edge wraps count to 0 and tick = 1 for that cycle.
- RUN, hold = 1: count, wave_out and pending config frozen; no tick. Hold is ignored in IDLE.
- Oneshot: the first wrap returns the block to IDLE. In that cycle tick = 1, done = 1, busy = 0, count = 0.
- start in RUN: count restarts at 0, no tick. Pending config is applied at the same edge.
- stop from any state: IDLE, count 0, wave_out 0. stop and start on the same edge: stop wins.
- wave_out: in RUN, equals (count < high) for the count shown in the same cycle; in IDLE it is 0. high ≥ period gives constant 1 in RUN; high = 0 gives constant 0.
- Comparisons are unsigned, WIDTH bits. The counter never exceeds period-1.

## Timing
- start sampled at edge E: from E, busy = 1, count = 0, wave_out = (high > 0).
- Ticks are exactly period cycles apart with hold low. The first tick comes period cycles after E.
- A config accepted in RUN takes effect in the first cycle after the next wrap. That period's tick is the last one at the old period.
- Reset may assert at any time. All outputs reach reset values asynchronously, with no glitch pulse on tick or done at deassertion.
- cfg_err pulse appears 1 cycle after the rejecting edge.

## Test plan
- Reset defaults: release rst, start, hold low → first tick 12_000_000 cycles after start. wave_out high for the first 6_000_000 cycles, then low. (Run with DEFAULT_PERIOD overridden to 10 / DEFAULT_HIGH 5 for simulation speed.)
- cfg period=4, high=1 in IDLE, then start → count 0,1,2,3,0…; wave_out 1,0,0,0,1…; tick in every cycle where count returns to 0 after a wrap, 4 cycles apart.
- In RUN at period 4, cfg period=6 at count=1 → cfg_ready low until the next wrap. Tick spacing goes 4, then 6, 6. A second cfg_valid while pending is not accepted.
- Oneshot period=5 → exactly one tick and done in the same cycle. busy drops and count is 0; no further ticks.
- Edge cases: cfg_period=1 → cfg_err pulse, config unchanged. start and stop on the same edge in RUN → IDLE. hold high for 3 cycles at count=2 → count stays 2 and the tick is delayed by 3 cycles.
- Assert rst mid-RUN with a config pending → all outputs at reset values immediately, pending config lost, cfg_ready = 1, DEFAULT_PERIOD active.
